// File: rtl/seq_bus_switch_sched_pkg.sv
// Shared types and helpers for the switching-limited bus scheduler.
//   state_e    : scheduler state (PASS / SPLIT)
//   BUS_NBITS  : width of the scheduled bus
//   popcount8  : number of set bits in an 8-bit value (0..8)
package seq_bus_switch_sched_pkg;

    localparam int BUS_NBITS = 8;

    typedef enum logic {
        PASS  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    function automatic logic [3:0] popcount8(input logic [BUS_NBITS-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < BUS_NBITS; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/seq_bus_hamming8.sv
// Combinational Hamming distance between two 8-bit bus values.
// Ports:
//   a_i  : first value
//   b_i  : second value
//   hd_o : number of differing bits, 0..8
module seq_bus_hamming8
    import seq_bus_switch_sched_pkg::*;
(
    input  logic [BUS_NBITS-1:0] a_i,
    input  logic [BUS_NBITS-1:0] b_i,
    output logic [3:0]           hd_o
);

    assign hd_o = popcount8(a_i ^ b_i);

endmodule

// File: rtl/seq_bus_switch_sched.sv
// Registered transmit scheduler for an 8-bit bus that limits how many bus
// bits may toggle between consecutive cycles. A word that would toggle more
// than HD_MAX bits is sent in two bus cycles: low nibble first (bus_val=0),
// then the full word (bus_val=1).
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   in_val/in_rdy   : producer handshake (in_rdy depends on state only)
//   in_msg          : producer word
//   bus_val, bus    : registered bus outputs; bus is a word when bus_val=1
//   split_count     : saturating count of split transfers, present only
//                     when SEQ_BUS_SWITCH_SCHED_STATS_EN is defined
// Parameter HD_MAX (4..8): toggle cap; 8 means no word is ever split.
module seq_bus_switch_sched
    import seq_bus_switch_sched_pkg::*;
#(
    parameter int HD_MAX = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [BUS_NBITS-1:0] in_msg,
    output logic                 bus_val,
    output logic [BUS_NBITS-1:0] bus
`ifdef SEQ_BUS_SWITCH_SCHED_STATS_EN
    ,
    output logic [15:0]          split_count
`endif
);

    localparam logic [3:0] HdMax = 4'(HD_MAX);

    state_e                 state_q, state_d;
    logic [BUS_NBITS-1:0]   bus_q, bus_d;
    logic [BUS_NBITS-1:0]   hold_q, hold_d;
    logic                   bus_val_q, bus_val_d;
    logic [3:0]             hd;
    logic                   fire;

    // Distance is always measured against the value currently on the bus,
    // including the full word just restored by a SPLIT cycle.
    seq_bus_hamming8 u_hd (
        .a_i  (in_msg),
        .b_i  (bus_q),
        .hd_o (hd)
    );

    assign in_rdy  = (state_q == PASS);
    assign fire    = in_val && in_rdy;
    assign bus_val = bus_val_q;
    assign bus     = bus_q;

    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        hold_d    = hold_q;
        bus_val_d = 1'b0;
        case (state_q)
            PASS: begin
                if (fire) begin
                    if (hd > HdMax) begin
                        // Each half changes at most one nibble, so at most
                        // 4 bits toggle per cycle.
                        bus_d   = {bus_q[7:4], in_msg[3:0]};
                        hold_d  = in_msg;
                        state_d = SPLIT;
                    end else begin
                        bus_d     = in_msg;
                        bus_val_d = 1'b1;
                    end
                end
            end
            SPLIT: begin
                bus_d     = hold_q;
                bus_val_d = 1'b1;
                state_d   = PASS;
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= PASS;
            bus_q     <= '0;
            hold_q    <= '0;
            bus_val_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            hold_q    <= hold_d;
            bus_val_q <= bus_val_d;
        end
    end

`ifdef SEQ_BUS_SWITCH_SCHED_STATS_EN
    logic [15:0] split_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            split_cnt_q <= '0;
        end else if (state_q == PASS && state_d == SPLIT && split_cnt_q != 16'hFFFF) begin
            split_cnt_q <= split_cnt_q + 16'd1;
        end
    end

    assign split_count = split_cnt_q;
`endif

endmodule

// File: doc/seq_bus_switch_sched.md
Name: seq_bus_switch_sched

Overview:
- Registered transmit scheduler for an 8-bit output bus.
- Accepts words over a val/rdy input.
- Caps per-cycle bus switching: when the next word would toggle more than HD_MAX bits relative to the currently driven bus value, the transfer is split into two bus cycles (lower nibble first, then upper).
- Sits between a word producer and a long on-chip bus; the companion worst-case switching monitor on that bus never fires when HD_MAX < 8.

Parameters:
- HD_MAX, 7, maximum Hamming distance allowed between consecutive bus values; legal range 4..8; 8 disables splitting.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_val  input  1  producer word valid
- in_rdy  output  1  scheduler can accept a word this cycle
- in_msg  input  8  producer word
- bus_val  output  1  bus carries a delivered word this cycle (registered)
- bus  output  8  driven bus value (registered)
- split_count  output  16  number of split transfers (only with SWITCH_STATS_EN)

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset). On reset: state=PASS, bus=0x00, bus_val=0, hold=0x00, split_count=0.
- Transfer fires when in_val && in_rdy.
- in_rdy is combinational from state only: 1 in PASS, 0 in SPLIT. It never depends on in_val.
- hd = popcount(in_msg ^ bus), an unsigned 4-bit value 0..8, computed against the current registered bus.
- State PASS:
  - Fire with hd <= HD_MAX: next bus=in_msg, bus_val=1, stay in PASS. Latency is 1 cycle.
  - Fire with hd > HD_MAX: next bus={bus[7:4], in_msg[3:0]}, bus_val=0 (intermediate value, not a word), hold=in_msg, go to SPLIT.
  - No fire: bus holds its value, bus_val=0.
- State SPLIT: next bus=hold, bus_val=1, go to PASS. The input is stalled for exactly one cycle. Total latency is 2 cycles.
- Each split half toggles at most 4 bits, so the HD_MAX >= 4 constraint guarantees the bound on every cycle.
- Throughput: 1 word/cycle with no splits; each split costs one extra cycle.
- Back-to-back words: hd always uses the bus value being driven this cycle, including the value just written by SPLIT.
- Equal consecutive words: hd=0, pass; bus_val=1, bus unchanged.
- Input idle for many cycles: bus holds its last value (no return to zero); hd continues to reference it.
- Reset asserted during SPLIT: hold is discarded, and the word is not delivered.
- HD_MAX=8: SPLIT is unreachable, and in_rdy is constant 1 out of reset.
- No output backpressure; the bus consumer samples bus only when bus_val=1.

Optional Feature:
- Macro: SEQ_BUS_SWITCH_SCHED_STATS_EN.
- Defined:
  - split_count port exists.
  - Increments by 1 on each PASS→SPLIT transition.
  - Saturates at 0xFFFF.
  - Reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - enum type for state {PASS, SPLIT}.
  - Constant BUS_NBITS=8.
  - popcount8 function returning 4 bits.
- One natural sub-module: seq_bus_hamming8, combinational, 8b XOR + popcount → 4-bit hd. It is reused by the switching monitor and by future bus encoders.
- FSM, bus/hold registers and counter stay in the top module.

Test Plan:
- Reset then in_val=1, in_msg=0x55 (hd=4 vs 0x00) → next cycle bus=0x55, bus_val=1, in_rdy stays 1.
- bus=0x55, send 0xAA (hd=8) → cycle+1: bus=0x5A, bus_val=0, in_rdy=0; cycle+2: bus=0xAA, bus_val=1; split_count=1 with the macro defined.
- Stream 0x00,0x0F,0xFF,0xF0 back-to-back with in_val held high (all hd<=4) → one word per cycle, no stalls, bus_val=1 each cycle.
- bus=0xAA, send 0x55 with 0x55 presented again during the stall → first 0x55 delivered via 0xA5 intermediate; the second 0x55 is accepted only after in_rdy returns (hd=0, pass).
- Assert reset asynchronously mid-SPLIT (hold=0xAA) → bus=0x00, bus_val=0, state PASS immediately; 0xAA is never delivered.
- HD_MAX=8 build, send 0x55 then 0xAA → no split; bus_val=1 on consecutive cycles; in_rdy constant 1.
